// File: rtl/palette_fade_lut.sv
// Run-time writable colour palette with a 2-stage pixel lookup, per-frame brightness fade
// and colour-key transparency flag. Self-clears the palette after every reset.
module palette_fade_lut #(
   parameter int unsigned NUM_ENTRIES = 16,
   parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES),
   parameter int unsigned CH_W        = 8,
   parameter int unsigned FADE_STEP   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [3*CH_W-1:0]   wr_rgb,
   output logic                wr_ready,
   output logic                init_busy,
   input  logic                pix_valid,
   input  logic [IDX_W-1:0]    pix_idx,
   input  logic [IDX_W-1:0]    key_idx,
   input  logic                frame_start,
   input  logic                fade_en,
   input  logic [CH_W-1:0]     fade_target,
   output logic                out_valid,
   output logic [3*CH_W-1:0]   out_rgb,
   output logic                out_transparent,
   output logic [CH_W-1:0]     brightness,
   output logic                fade_done
);

   localparam int unsigned      RGB_W    = 3 * CH_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
   localparam logic [CH_W:0]    STEP     = (CH_W + 1)'(FADE_STEP);
   localparam logic [CH_W-1:0]  FULL     = {CH_W{1'b1}};

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e           state_q;
   logic [IDX_W-1:0] clr_cnt_q;

   logic [RGB_W-1:0] mem [NUM_ENTRIES];

   logic             s1_valid_q;
   logic [RGB_W-1:0] s1_rgb_q;
   logic             s1_key_q;

   logic [CH_W:0]    bright_p1;
   logic [RGB_W-1:0] scaled;

   logic [CH_W-1:0]  bright_d;
   logic [CH_W:0]    bright_up;
   logic [CH_W:0]    bright_floor;

   // Control FSM: INIT walks the clear counter across every entry, then RUN accepts writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StInit;
         clr_cnt_q <= '0;
         init_busy <= 1'b1;
         wr_ready  <= 1'b0;
      end else begin
         unique case (state_q)
            StInit: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (clr_cnt_q == LAST_IDX) begin
                  state_q   <= StRun;
                  init_busy <= 1'b0;
                  wr_ready  <= 1'b1;
               end
            end
            StRun: begin
               init_busy <= 1'b0;
               wr_ready  <= 1'b1;
            end
         endcase
      end
   end

   // Host writes are silently dropped while the clear sweep owns the write port.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == StInit) begin
            mem[clr_cnt_q] <= '0;
         end else if (wr_en) begin
            mem[wr_idx] <= wr_rgb;
         end
      end
   end

   // Stage 1: registered read returns pre-write contents on a same-index collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= pix_valid;
      end
      if (pix_valid) begin
         s1_rgb_q <= mem[pix_idx];
         s1_key_q <= (pix_idx == key_idx);
      end
   end

   function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                                input logic [CH_W:0]   k);
      logic [2*CH_W:0] prod;
      prod = {{(CH_W + 1){1'b0}}, c} * {{CH_W{1'b0}}, k};
      return CH_W'(prod >> CH_W);
   endfunction

   // Multiplying by brightness+1 makes full brightness an exact identity.
   assign bright_p1 = {1'b0, brightness} + 1'b1;

   always_comb begin
      scaled = '0;
      for (int ch = 0; ch < 3; ch++) begin
         scaled[ch*CH_W +: CH_W] = scale_ch(s1_rgb_q[ch*CH_W +: CH_W], bright_p1);
      end
   end

   // Stage 2: outputs hold their last value on idle cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid       <= 1'b0;
         out_rgb         <= '0;
         out_transparent <= 1'b0;
      end else begin
         out_valid <= s1_valid_q;
         if (s1_valid_q) begin
            out_rgb         <= scaled;
            out_transparent <= s1_key_q;
         end
      end
   end

   // One extra bit keeps the step from wrapping past either end of the range.
   always_comb begin
      bright_d     = brightness;
      bright_up    = {1'b0, brightness} + STEP;
      bright_floor = {1'b0, fade_target} + STEP;
      if (state_q == StRun && frame_start && fade_en) begin
         if (brightness < fade_target) begin
            bright_d = (bright_up >= {1'b0, fade_target}) ? fade_target : bright_up[CH_W-1:0];
         end else if (brightness > fade_target) begin
            bright_d = ({1'b0, brightness} >= bright_floor) ?
                       brightness - STEP[CH_W-1:0] : fade_target;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         brightness <= FULL;
         fade_done  <= 1'b0;
      end else begin
         brightness <= bright_d;
         fade_done  <= (brightness == fade_target);
      end
   end

endmodule

// File: tb/tb_palette_fade_lut.sv
// Scoreboard bench for palette_fade_lut: randomized and directed traffic against a
// behavioural palette/fade model; a separate monitor checks every cycle.
module tb_palette_fade_lut;

   localparam int N    = 16;
   localparam int STEP = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [3:0]  wr_idx;
   logic [23:0] wr_rgb;
   logic        wr_ready;
   logic        init_busy;
   logic        pix_valid;
   logic [3:0]  pix_idx;
   logic [3:0]  key_idx;
   logic        frame_start;
   logic        fade_en;
   logic [7:0]  fade_target;
   logic        out_valid;
   logic [23:0] out_rgb;
   logic        out_transparent;
   logic [7:0]  brightness;
   logic        fade_done;

   always #5 clk = ~clk;

   palette_fade_lut #(
      .NUM_ENTRIES (N),
      .CH_W        (8),
      .FADE_STEP   (STEP)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .wr_en           (wr_en),
      .wr_idx          (wr_idx),
      .wr_rgb          (wr_rgb),
      .wr_ready        (wr_ready),
      .init_busy       (init_busy),
      .pix_valid       (pix_valid),
      .pix_idx         (pix_idx),
      .key_idx         (key_idx),
      .frame_start     (frame_start),
      .fade_en         (fade_en),
      .fade_target     (fade_target),
      .out_valid       (out_valid),
      .out_rgb         (out_rgb),
      .out_transparent (out_transparent),
      .brightness      (brightness),
      .fade_done       (fade_done)
   );

   typedef struct {
      int          cyc;
      logic [23:0] rgb;
      logic        tr;
   } exp_t;

   exp_t sb[$];

   // Reference model state, owned by the driver.
   int m_mem[N];
   bit m_init;
   int m_cnt;
   int m_bright;
   bit m_fdone;
   int cyc       = 0;
   int rst_count = 0;
   bit armed     = 1'b0;
   bit done      = 1'b0;

   int checks = 0;
   int errors = 0;

   function automatic logic [23:0] scale(input int rgb, input int b);
      int r, g, bl;
      r  = (((rgb >> 16) & 255) * (b + 1)) >> 8;
      g  = (((rgb >> 8) & 255) * (b + 1)) >> 8;
      bl = ((rgb & 255) * (b + 1)) >> 8;
      return {r[7:0], g[7:0], bl[7:0]};
   endfunction

   task automatic model_edge();
      int   t;
      exp_t e;
      cyc++;
      if (reset) begin
         m_init   = 1'b1;
         m_cnt    = 0;
         m_bright = 255;
         m_fdone  = 1'b0;
         sb.delete();
         rst_count++;
         armed = 1'b1;
         return;
      end
      if (!armed) return;
      t       = int'(fade_target);
      m_fdone = (m_bright == t);
      if (!m_init && frame_start && fade_en) begin
         if (m_bright < t) m_bright = (m_bright + STEP > t) ? t : m_bright + STEP;
         else if (m_bright > t) m_bright = (m_bright - STEP < t) ? t : m_bright - STEP;
      end
      if (pix_valid) begin
         e.cyc = cyc + 1;
         e.rgb = scale(m_mem[pix_idx], m_bright);
         e.tr  = (pix_idx == key_idx);
         sb.push_back(e);
      end
      if (m_init) begin
         m_mem[m_cnt] = 0;
         m_cnt++;
         if (m_cnt == N) m_init = 1'b0;
      end else if (wr_en) begin
         m_mem[wr_idx] = int'(wr_rgb);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      wr_en       = 1'b0;
      pix_valid   = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic do_write(input int idx, input logic [23:0] rgb);
      wr_en  = 1'b1;
      wr_idx = 4'(idx);
      wr_rgb = rgb;
      tick();
   endtask

   task automatic do_lookup(input int idx);
      pix_valid = 1'b1;
      pix_idx   = 4'(idx);
      tick();
   endtask

   task automatic random_cycle(input bit allow_fade);
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_idx    = 4'($urandom_range(0, N - 1));
      wr_rgb    = 24'($urandom);
      pix_valid = ($urandom_range(0, 1) == 1);
      pix_idx   = 4'($urandom_range(0, N - 1));
      if ($urandom_range(0, 15) == 0) key_idx = 4'($urandom_range(0, N - 1));
      if (allow_fade) begin
         frame_start = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 31) == 0) fade_en = ~fade_en;
         if ($urandom_range(0, 63) == 0) fade_target = 8'($urandom);
      end
      tick();
   endtask

   // Driver
   initial begin
      reset       = 1'b1;
      wr_en       = 1'b0;
      wr_idx      = '0;
      wr_rgb      = '0;
      pix_valid   = 1'b0;
      pix_idx     = '0;
      key_idx     = '0;
      frame_start = 1'b0;
      fade_en     = 1'b0;
      fade_target = 8'd255;
      repeat (3) tick();
      reset = 1'b0;

      // Writes during the power-up clear must be dropped.
      for (int i = 0; i < 40 && m_init; i++) begin
         wr_en  = ($urandom_range(0, 1) == 1);
         wr_idx = 4'($urandom_range(0, N - 1));
         wr_rgb = 24'($urandom | 1);
         tick();
      end
      for (int i = 0; i < N; i++) do_lookup(i);

      do_write(3, 24'h87CEEB);
      do_lookup(3);
      tick();

      // Same-cycle collision returns old contents.
      wr_en     = 1'b1;
      wr_idx    = 4'd5;
      wr_rgb    = 24'hFF0000;
      pix_valid = 1'b1;
      pix_idx   = 4'd5;
      tick();
      do_lookup(5);

      do_write(6, 24'h112233);
      do_write(7, 24'h445566);
      do_write(8, 24'h778899);
      key_idx = 4'd7;
      for (int i = 6; i <= 8; i++) do_lookup(i);
      tick();

      fade_en = 1'b1;
      for (int i = 0; i < 300; i++) random_cycle(1'b1);

      // Directed fade: back to full, down to 0, then up to 128.
      frame_start = 1'b0;
      fade_en     = 1'b1;
      fade_target = 8'd255;
      for (int i = 0; i < 80 && m_bright != 255; i++) begin
         frame_start = 1'b1;
         tick();
      end
      do_write(3, 24'h87CEEB);
      fade_target = 8'd0;
      for (int i = 0; i < 64; i++) begin
         frame_start = 1'b1;
         tick();
         tick();
      end
      tick();
      do_lookup(3);
      fade_target = 8'd128;
      for (int i = 0; i < 40; i++) begin
         frame_start = 1'b1;
         pix_valid   = 1'b1;
         pix_idx     = 4'd3;
         tick();
      end

      // Reset mid-stream and mid-fade.
      fade_target = 8'd255;
      for (int i = 0; i < 12; i++) begin
         frame_start = 1'b1;
         pix_valid   = 1'b1;
         pix_idx     = 4'($urandom_range(0, N - 1));
         tick();
      end
      reset     = 1'b1;
      pix_valid = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 24; i++) random_cycle(1'b1);
      for (int i = 0; i < N; i++) do_lookup(i);
      for (int i = 0; i < 100; i++) random_cycle(1'b1);

      repeat (5) tick();
      done = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      int          last_rst = 0;
      int          guard    = 0;
      logic [23:0] hold_rgb = '0;
      logic        hold_tr  = 1'b0;
      exp_t        e;
      while (!done) begin
         @(posedge clk);
         #2;
         guard++;
         if (guard > 20000) begin
            chk("watchdog", 32'(guard), 32'd20000);
            break;
         end
         if (!armed) continue;
         if (rst_count != last_rst) begin
            last_rst = rst_count;
            hold_rgb = '0;
            hold_tr  = 1'b0;
         end
         chk("init_busy", 32'(init_busy), 32'(m_init));
         chk("wr_ready", 32'(wr_ready), 32'(!m_init));
         chk("brightness", 32'(brightness), 32'(m_bright));
         chk("fade_done", 32'(fade_done), 32'(m_fdone));
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("latency", 32'(cyc), 32'(e.cyc));
               chk("out_rgb", 32'(out_rgb), 32'(e.rgb));
               chk("out_transparent", 32'(out_transparent), 32'(e.tr));
               hold_rgb = e.rgb;
               hold_tr  = e.tr;
            end
         end else begin
            chk("out_valid_low", 32'(out_valid), 32'd0);
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
               chk("missing_out_valid", 32'd0, 32'd1);
               void'(sb.pop_front());
            end
            chk("out_rgb_hold", 32'(out_rgb), 32'(hold_rgb));
            chk("out_transparent_hold", 32'(out_transparent), 32'(hold_tr));
         end
      end
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
